// File: rtl/rast_ms_sched_if.sv
// Pixel request, sample-pipe and coverage-record signals of the multisample scheduler.
// master: the scheduler's view. slave: the surrounding pipeline's view.
interface rast_ms_sched_if #(
    parameter int unsigned SIGFIG      = 24,
    parameter int unsigned VERTS       = 3,
    parameter int unsigned AXIS        = 3,
    parameter int unsigned NUM_SAMPLES = 4
);
    localparam int unsigned SI   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned TRIW = VERTS * AXIS * SIGFIG;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [TRIW-1:0]        in_tri_i;
    logic [SIGFIG-1:0]      in_x_i;
    logic [SIGFIG-1:0]      in_y_i;

    logic                   samp_valid_o;
    logic [TRIW-1:0]        samp_tri_o;
    logic [SIGFIG-1:0]      samp_x_o;
    logic [SIGFIG-1:0]      samp_y_o;
    logic [SI-1:0]          samp_idx_o;

    logic                   hit_valid_i;
    logic                   hit_i;
    logic [SI-1:0]          hit_idx_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [SIGFIG-1:0]      out_x_o;
    logic [SIGFIG-1:0]      out_y_o;
    logic [NUM_SAMPLES-1:0] out_mask_o;
    logic                   out_any_o;
    logic                   err_o;

    modport master (
        input  in_valid_i, in_tri_i, in_x_i, in_y_i,
        input  hit_valid_i, hit_i, hit_idx_i,
        input  out_ready_i,
        output in_ready_o,
        output samp_valid_o, samp_tri_o, samp_x_o, samp_y_o, samp_idx_o,
        output out_valid_o, out_x_o, out_y_o, out_mask_o, out_any_o, err_o
    );

    modport slave (
        output in_valid_i, in_tri_i, in_x_i, in_y_i,
        output hit_valid_i, hit_i, hit_idx_i,
        output out_ready_i,
        input  in_ready_o,
        input  samp_valid_o, samp_tri_o, samp_x_o, samp_y_o, samp_idx_o,
        input  out_valid_o, out_x_o, out_y_o, out_mask_o, out_any_o, err_o
    );
endinterface

// File: rtl/rast_ms_sched.sv
// Multisample scheduler: issues NUM_SAMPLES sample positions per pixel into a fixed-latency
// sample pipe and reassembles in-order hit results into per-pixel coverage records.
// Credits bound in-flight pixels so neither the tag FIFO nor the output FIFO can overflow.
module rast_ms_sched #(
    parameter int unsigned SIGFIG       = 24,
    parameter int unsigned RADIX        = 10,
    parameter int unsigned VERTS        = 3,
    parameter int unsigned AXIS         = 3,
    parameter int unsigned NUM_SAMPLES  = 4,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic           clk,
    input  logic           rst,
    rast_ms_sched_if.master bus
);
    localparam int unsigned SI    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned TRIW  = VERTS * AXIS * SIGFIG;
    localparam int unsigned PW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CW    = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned LAST  = NUM_SAMPLES - 1;
    localparam int unsigned SHIFT = RADIX - 4;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [SIGFIG-1:0] x;
        logic [SIGFIG-1:0] y;
    } tag_t;

    typedef struct packed {
        logic [SIGFIG-1:0]      x;
        logic [SIGFIG-1:0]      y;
        logic [NUM_SAMPLES-1:0] mask;
    } rec_t;

    // Sub-pixel offset of sample k in 1/16 pixel, packed as {ox, oy}.
    function automatic logic [7:0] samp_ofs(input logic [SI-1:0] k);
        int unsigned ki;
        ki = 32'(k);
        samp_ofs = 8'h88;
        if (NUM_SAMPLES == 2) begin
            samp_ofs = (ki == 0) ? 8'h44 : 8'hCC;
        end else if (NUM_SAMPLES == 4) begin
            case (ki)
                0:       samp_ofs = 8'h62;
                1:       samp_ofs = 8'hE6;
                2:       samp_ofs = 8'h2A;
                default: samp_ofs = 8'hAE;
            endcase
        end
    endfunction

    // Pixel corner plus offset scaled to fixed point; wraps modulo 2^SIGFIG.
    function automatic logic [SIGFIG-1:0] samp_pos(input logic [SIGFIG-1:0] base,
                                                   input logic [3:0] o);
        samp_pos = base + (SIGFIG'(o) << SHIFT);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t            state_q, state_n;
    logic [SI-1:0]     cnt_q, cnt_n;
    logic              load_px;
    logic [TRIW-1:0]   tri_q;
    logic [SIGFIG-1:0] x_q, y_q;
    logic [SIGFIG-1:0] samp_x_q, samp_y_q, samp_x_n, samp_y_n;
    logic [CW-1:0]     credits_q, credits_n;
    logic              ready_q, ready_n;
    logic              accept, pop;

    tag_t              tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]     tag_wr_q, tag_rd_q;
    logic [CW-1:0]     tag_cnt_q;
    rec_t              out_mem [MAX_INFLIGHT];
    logic [PW-1:0]     out_wr_q, out_rd_q;
    logic [CW-1:0]     out_cnt_q;

    logic [NUM_SAMPLES-1:0] mask_q, mask_fin;
    logic [SI-1:0]     exp_q;
    logic              err_q;
    logic              hit_ok, hit_bad, hit_last;
    logic [7:0]        ofs;

    assign accept = bus.in_valid_i & ready_q;
    assign pop    = (out_cnt_q != '0) & bus.out_ready_i;

    // Issue FSM next state, sample position and ready/credit bookkeeping.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        load_px  = 1'b0;
        samp_x_n = samp_x_q;
        samp_y_n = samp_y_q;
        ofs      = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = ISSUE;
                    cnt_n   = '0;
                    load_px = 1'b1;
                end
            end
            ISSUE: begin
                if (cnt_q == SI'(LAST)) begin
                    if (accept) begin
                        cnt_n   = '0;
                        load_px = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + SI'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == ISSUE) begin
            ofs = samp_ofs(cnt_n);
            if (load_px) begin
                samp_x_n = samp_pos(bus.in_x_i, ofs[7:4]);
                samp_y_n = samp_pos(bus.in_y_i, ofs[3:0]);
            end else begin
                samp_x_n = samp_pos(x_q, ofs[7:4]);
                samp_y_n = samp_pos(y_q, ofs[3:0]);
            end
        end
        credits_n = credits_q - CW'(accept) + CW'(pop);
        ready_n   = ((state_n == IDLE) || ((state_n == ISSUE) && (cnt_n == SI'(LAST))))
                    && (credits_n != '0);
    end

    // Result checking against the running index and mask merge.
    always_comb begin
        hit_ok   = 1'b0;
        hit_bad  = 1'b0;
        hit_last = 1'b0;
        mask_fin = mask_q;
        if (bus.hit_valid_i) begin
            if ((tag_cnt_q != '0) && (bus.hit_idx_i == exp_q)) begin
                hit_ok   = 1'b1;
                hit_last = (bus.hit_idx_i == SI'(LAST));
                mask_fin[bus.hit_idx_i] = bus.hit_i;
            end else begin
                hit_bad = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Pixel, sample, credit and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            samp_x_q  <= '0;
            samp_y_q  <= '0;
            credits_q <= CW'(MAX_INFLIGHT);
            ready_q   <= 1'b0;
        end else begin
            if (load_px) begin
                tri_q <= bus.in_tri_i;
                x_q   <= bus.in_x_i;
                y_q   <= bus.in_y_i;
            end
            samp_x_q  <= samp_x_n;
            samp_y_q  <= samp_y_n;
            credits_q <= credits_n;
            ready_q   <= ready_n;
        end
    end

    // Tag FIFO, mask accumulator, output FIFO and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                tag_mem[i] <= '0;
                out_mem[i] <= '0;
            end
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            mask_q    <= '0;
            exp_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                tag_mem[tag_wr_q] <= '{x: bus.in_x_i, y: bus.in_y_i};
                tag_wr_q          <= ptr_inc(tag_wr_q);
            end
            if (hit_last) begin
                tag_rd_q          <= ptr_inc(tag_rd_q);
                out_mem[out_wr_q] <= '{x: tag_mem[tag_rd_q].x, y: tag_mem[tag_rd_q].y,
                                       mask: mask_fin};
                out_wr_q          <= ptr_inc(out_wr_q);
                mask_q            <= '0;
                exp_q             <= '0;
            end else if (hit_ok) begin
                mask_q <= mask_fin;
                exp_q  <= exp_q + SI'(1);
            end
            if (pop) begin
                out_rd_q <= ptr_inc(out_rd_q);
            end
            tag_cnt_q <= tag_cnt_q + CW'(accept) - CW'(hit_last);
            out_cnt_q <= out_cnt_q + CW'(hit_last) - CW'(pop);
            if (hit_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o   = ready_q;
    assign bus.samp_valid_o = (state_q == ISSUE);
    assign bus.samp_idx_o   = cnt_q;
    assign bus.samp_tri_o   = tri_q;
    assign bus.samp_x_o     = samp_x_q;
    assign bus.samp_y_o     = samp_y_q;
    assign bus.out_valid_o  = (out_cnt_q != '0);
    assign bus.out_x_o      = out_mem[out_rd_q].x;
    assign bus.out_y_o      = out_mem[out_rd_q].y;
    assign bus.out_mask_o   = out_mem[out_rd_q].mask;
    assign bus.out_any_o    = |out_mem[out_rd_q].mask;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_rast_ms_sched.sv
// Directed bench for rast_ms_sched with a fixed-latency echo model of the sample pipe.
module tb_rast_ms_sched;
    localparam int SIGFIG       = 24;
    localparam int RADIX        = 10;
    localparam int VERTS        = 3;
    localparam int AXIS         = 3;
    localparam int NUM_SAMPLES  = 4;
    localparam int MAX_INFLIGHT = 2;
    localparam int PIPES_SAMP   = 2;
    localparam int SI           = 2;
    localparam int TRIW         = VERTS * AXIS * SIGFIG;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rast_ms_sched_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS),
                       .NUM_SAMPLES(NUM_SAMPLES)) bus ();

    rast_ms_sched #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
                    .NUM_SAMPLES(NUM_SAMPLES), .MAX_INFLIGHT(MAX_INFLIGHT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Sample pipe echo: returns hit_pat[idx] PIPES_SAMP cycles after issue.
    logic [PIPES_SAMP-1:0] pv;
    logic [SI-1:0]         pidx [PIPES_SAMP];
    logic [3:0]            hit_pat;
    logic                  echo_en;
    logic                  force_en, force_v, force_hit;
    logic [SI-1:0]         force_idx;
    logic [TRIW-1:0]       tri_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < PIPES_SAMP; i++) pidx[i] <= '0;
        end else begin
            pv[0]   <= bus.samp_valid_o & echo_en;
            pidx[0] <= bus.samp_idx_o;
            for (int i = 1; i < PIPES_SAMP; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    assign bus.hit_valid_i = force_en ? force_v   : pv[PIPES_SAMP-1];
    assign bus.hit_idx_i   = force_en ? force_idx : pidx[PIPES_SAMP-1];
    assign bus.hit_i       = force_en ? force_hit : hit_pat[pidx[PIPES_SAMP-1]];

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready_o, bus.samp_valid_o, bus.out_valid_o, bus.err_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {bus.in_ready_o, bus.samp_valid_o, bus.out_valid_o, bus.err_o});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.in_ready_o);
        end
    endtask

    task automatic test_issue();
        logic [SIGFIG-1:0] ex [4];
        logic [SIGFIG-1:0] ey [4];
        ex = '{24'd5504, 24'd6016, 24'd5248, 24'd5760};
        ey = '{24'd3200, 24'd3456, 24'd3712, 24'd3968};
        hit_pat = 4'b1101;
        echo_en = 1'b1;
        bus.out_ready_i = 1'b0;
        bus.in_x_i = 24'd5120;
        bus.in_y_i = 24'd3072;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.samp_valid_o, bus.samp_idx_o, bus.samp_x_o, bus.samp_y_o}
                !== {1'b1, SI'(k), ex[k], ey[k]}) begin
                failures++;
                $display("FAIL issue_sample%0d got v=%b idx=%0d x=%0d y=%0d exp v=1 idx=%0d x=%0d y=%0d",
                         k, bus.samp_valid_o, bus.samp_idx_o, bus.samp_x_o, bus.samp_y_o,
                         k, ex[k], ey[k]);
            end
            if (k == 0) begin
                checks++;
                if ({bus.samp_tri_o, bus.in_ready_o} !== {tri_val, 1'b0}) begin
                    failures++;
                    $display("FAIL issue_tri_ready got ready=%b tri_ok=%b exp ready=0 tri_ok=1",
                             bus.in_ready_o, bus.samp_tri_o === tri_val);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.in_ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL issue_ready_last got=%b exp=1", bus.in_ready_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus.samp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL issue_end_valid got=%b exp=0", bus.samp_valid_o);
        end
        for (int i = 0; i < 20 && !bus.out_valid_o; i++) @(negedge clk);
        checks++;
        if ({bus.out_valid_o, bus.out_x_o, bus.out_y_o, bus.out_mask_o, bus.out_any_o}
            !== {1'b1, 24'd5120, 24'd3072, 4'b1101, 1'b1}) begin
            failures++;
            $display("FAIL record_t2 got v=%b x=%0d y=%0d mask=%b any=%b exp v=1 x=5120 y=3072 mask=1101 any=1",
                     bus.out_valid_o, bus.out_x_o, bus.out_y_o, bus.out_mask_o, bus.out_any_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid_o, bus.out_x_o, bus.out_mask_o} !== {1'b1, 24'd5120, 4'b1101}) begin
            failures++;
            $display("FAIL record_hold got v=%b x=%0d mask=%b exp v=1 x=5120 mask=1101",
                     bus.out_valid_o, bus.out_x_o, bus.out_mask_o);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL record_pop got v=%b exp v=0", bus.out_valid_o);
        end
    endtask

    task automatic test_credits();
        int acc;
        int got;
        acc = 0;
        got = 0;
        hit_pat = 4'b0000;
        bus.out_ready_i = 1'b0;
        bus.in_y_i = 24'd2048;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid_i = 1'b1;
            bus.in_x_i = SIGFIG'((acc + 1) * 1024);
            if (bus.in_ready_o) acc++;
            @(negedge clk);
        end
        checks++;
        if ({acc, bus.in_ready_o} !== {32'd2, 1'b0}) begin
            failures++;
            $display("FAIL credit_stall got acc=%0d ready=%b exp acc=2 ready=0", acc, bus.in_ready_o);
        end
        checks++;
        if ({bus.out_valid_o, bus.out_x_o, bus.out_mask_o, bus.out_any_o}
            !== {1'b1, 24'd1024, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL credit_head got v=%b x=%0d mask=%b any=%b exp v=1 x=1024 mask=0000 any=0",
                     bus.out_valid_o, bus.out_x_o, bus.out_mask_o, bus.out_any_o);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        checks++;
        if ({bus.out_x_o, bus.in_ready_o} !== {24'd2048, 1'b1}) begin
            failures++;
            $display("FAIL credit_return got x=%0d ready=%b exp x=2048 ready=1",
                     bus.out_x_o, bus.in_ready_o);
        end
        if (bus.in_ready_o) acc++;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (bus.out_valid_o) begin
                checks++;
                if ({bus.out_x_o, bus.out_mask_o, bus.out_any_o}
                    !== {SIGFIG'((got + 2) * 1024), 4'b0000, 1'b0}) begin
                    failures++;
                    $display("FAIL credit_order got x=%0d mask=%b any=%b exp x=%0d mask=0000 any=0",
                             bus.out_x_o, bus.out_mask_o, bus.out_any_o, (got + 2) * 1024);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b0;
        checks++;
        if ({acc, got} !== {32'd3, 32'd2}) begin
            failures++;
            $display("FAIL credit_count got acc=%0d drained=%0d exp acc=3 drained=2", acc, got);
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        int nacc;
        int gaps;
        prev = -1;
        nacc = 0;
        gaps = 0;
        hit_pat = 4'b1010;
        bus.out_ready_i = 1'b1;
        bus.in_x_i = 24'd0;
        bus.in_y_i = 24'd1024;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid_i = 1'b1;
            if (prev >= 0 && bus.samp_valid_o !== 1'b1) gaps++;
            if (bus.out_valid_o) begin
                checks++;
                if (bus.out_mask_o !== 4'b1010) begin
                    failures++;
                    $display("FAIL b2b_mask got=%b exp=1010", bus.out_mask_o);
                end
            end
            if (bus.in_ready_o) begin
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 4) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=4", c - prev);
                    end
                end
                prev = c;
                nacc++;
            end
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        checks++;
        if ({nacc, gaps} !== {32'd10, 32'd0}) begin
            failures++;
            $display("FAIL b2b_rate got accepts=%0d gaps=%0d exp accepts=10 gaps=0", nacc, gaps);
        end
        repeat (20) @(negedge clk);
        bus.out_ready_i = 1'b0;
        checks++;
        if ({bus.out_valid_o, bus.samp_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_drain got out_v=%b samp_v=%b exp 0 0", bus.out_valid_o, bus.samp_valid_o);
        end
    endtask

    task automatic test_errors();
        echo_en = 1'b0;
        force_en = 1'b1;
        force_hit = 1'b1;
        force_idx = '0;
        force_v = 1'b1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_before got=%b exp=0", bus.err_o);
        end
        @(negedge clk);
        force_v = 1'b0;
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_no_tag got=%b exp=1", bus.err_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.err_o, bus.out_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL err_sticky got err=%b out_v=%b exp err=1 out_v=0", bus.err_o, bus.out_valid_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got=%b exp=0", bus.err_o);
        end
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        force_idx = SI'(2);
        force_v = 1'b1;
        @(negedge clk);
        force_v = 1'b0;
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_bad_idx got=%b exp=1", bus.err_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_en = 1'b0;
        echo_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stale;
        int acc;
        stale = 0;
        acc = 0;
        hit_pat = 4'b1111;
        bus.out_ready_i = 1'b0;
        bus.in_x_i = 24'd5120;
        bus.in_y_i = 24'd3072;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 10 && !(bus.samp_valid_o && bus.samp_idx_o == SI'(2)); i++) @(negedge clk);
        checks++;
        if ({bus.samp_valid_o, bus.samp_idx_o, bus.samp_x_o} !== {1'b1, SI'(2), 24'd5248}) begin
            failures++;
            $display("FAIL midrst_reach got v=%b idx=%0d x=%0d exp v=1 idx=2 x=5248",
                     bus.samp_valid_o, bus.samp_idx_o, bus.samp_x_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready_o, bus.samp_valid_o, bus.samp_x_o, bus.samp_y_o, bus.samp_idx_o,
             bus.samp_tri_o, bus.out_valid_o, bus.out_x_o, bus.out_y_o, bus.out_mask_o,
             bus.out_any_o, bus.err_o} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got ready=%b sv=%b sx=%0d ov=%b err=%b exp all zero",
                     bus.in_ready_o, bus.samp_valid_o, bus.samp_x_o, bus.out_valid_o, bus.err_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready got=%b exp=1", bus.in_ready_o);
        end
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid_o) stale++;
            @(negedge clk);
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midrst_stale got=%0d exp=0", stale);
        end
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.in_valid_i = 1'b1;
            if (bus.in_ready_o) acc++;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        checks++;
        if (acc !== 2) begin
            failures++;
            $display("FAIL midrst_credits got=%0d exp=2", acc);
        end
        bus.out_ready_i = 1'b1;
        repeat (30) @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        tri_val = {9{24'h00A5C3}};
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_tri_i = tri_val;
        bus.in_x_i = '0;
        bus.in_y_i = '0;
        bus.out_ready_i = 1'b0;
        hit_pat = 4'b0000;
        echo_en = 1'b1;
        force_en = 1'b0;
        force_v = 1'b0;
        force_hit = 1'b0;
        force_idx = '0;
        test_reset();
        test_issue();
        test_credits();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
